// File: rtl/mux_rr_reg.sv
// -----------------------------------------------------------------------------
// mux_rr_reg
//
// Round-robin N:1 multiplexer with a registered output stage. N producers, each
// W bits wide with a valid/ready handshake, share one output bus. One channel
// is granted per cycle, searching upward from a rotating pointer. The granted
// beat is captured in a single output register that has its own valid/ready
// handshake.
//
// Parameters:
//   N   number of input channels (N >= 2)
//   W   data width per channel
//   SW  channel index width, $clog2(N). It is derived and cannot be overridden.
//
// Ports:
//   CLK        clock; all state updates on the rising edge
//   RST        asynchronous, active-high reset
//   IN_DATA    packed channel data; channel i is IN_DATA[i*W +: W]
//   IN_VALID   per-channel valid
//   IN_READY   per-channel ready; at most one bit is high, and it is
//              combinational from IN_VALID, the pointer and the output stage
//   OUT_DATA   registered data of the granted beat
//   OUT_SEL    index of the channel that produced OUT_DATA
//   OUT_VALID  OUT_DATA/OUT_SEL hold a beat
//   OUT_READY  downstream accepts the beat
//   IN_LAST    last beat of a packet per channel. This port exists only when
//              MUX_RR_LOCK_EN is defined.
//
// Optional feature (macro MUX_RR_LOCK_EN):
//   With the macro defined, a packet lock keeps the grant on one channel until
//   that channel transfers a beat with IN_LAST set. Other channels are not
//   served during the lock, even while the locked channel is idle.
//   With the macro undefined, arbitration runs on every beat.
// -----------------------------------------------------------------------------
module mux_rr_reg #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N*W-1:0]       IN_DATA,
  input  logic [N-1:0]         IN_VALID,
  output logic [N-1:0]         IN_READY,
  output logic [W-1:0]         OUT_DATA,
  output logic [$clog2(N)-1:0] OUT_SEL,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY
`ifdef MUX_RR_LOCK_EN
  ,
  input  logic [N-1:0]         IN_LAST
`endif
);

  localparam int SW = $clog2(N);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SW-1:0] ptr_q,       ptr_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_sel_q,   out_sel_d;
  logic          out_valid_q, out_valid_d;

  // ---------------------------------------------------------------------------
  // Arbitration signals
  // ---------------------------------------------------------------------------
  logic          acc;           // output register can take a beat this cycle
  logic [SW-1:0] rr_grant;      // round-robin winner
  logic          rr_grant_vld;
  logic [SW-1:0] grant;         // effective winner, after any packet lock
  logic          grant_vld;
  logic          xfer;          // a beat moves from the granted channel

  // The register is free when it is empty or is being drained in this cycle.
  // In the drain case, a new beat replaces the old one with no bubble.
  assign acc = !out_valid_q || OUT_READY;

  // Round-robin search. Channel ptr_q has the highest priority, then the
  // search wraps upward modulo N. The first valid channel found wins.
  always_comb begin
    int idx;
    // NOTE: Every signal written in always_comb gets a default before any
    // conditional code. Otherwise a path that skips the assignment infers a
    // latch.
    rr_grant     = '0;
    rr_grant_vld = 1'b0;
    idx          = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!rr_grant_vld && IN_VALID[idx]) begin
        rr_grant_vld = 1'b1;
        rr_grant     = SW'(idx);
      end
    end
  end

`ifdef MUX_RR_LOCK_EN
  // ---------------------------------------------------------------------------
  // Packet lock FSM: UNLOCKED / LOCKED(lock_ch_q)
  // ---------------------------------------------------------------------------
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e   lock_state_q, lock_state_d;
  logic [SW-1:0] lock_ch_q,    lock_ch_d;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_state_q <= UNLOCKED;
      lock_ch_q    <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_ch_q    <= lock_ch_d;
    end
  end

  // Next-state logic. A beat that is not the last one of its packet opens a
  // lock. The locked channel's last beat releases the lock.
  always_comb begin
    lock_state_d = lock_state_q;
    lock_ch_d    = lock_ch_q;
    case (lock_state_q)
      UNLOCKED: begin
        if (xfer && !IN_LAST[grant]) begin
          lock_state_d = LOCKED;
          lock_ch_d    = grant;
        end
      end
      LOCKED: begin
        if (xfer && IN_LAST[lock_ch_q]) begin
          lock_state_d = UNLOCKED;
        end
      end
      default: lock_state_d = UNLOCKED;
    endcase
  end

  // Output logic. While locked, the grant is pinned to the locked channel. If
  // that channel is idle, no channel is granted.
  always_comb begin
    grant     = rr_grant;
    grant_vld = rr_grant_vld;
    if (lock_state_q == LOCKED) begin
      grant     = lock_ch_q;
      grant_vld = IN_VALID[lock_ch_q];
    end
  end
`else
  assign grant     = rr_grant;
  assign grant_vld = rr_grant_vld;
`endif

  // IN_READY is held low while RST is asserted. This covers the mid-operation
  // reset case, where nothing may be taken before the pointer restarts.
  assign xfer = acc && grant_vld && !RST;

  always_comb begin
    IN_READY = '0;
    if (xfer) IN_READY[grant] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Output register and rotation pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = IN_DATA[int'(grant)*W +: W];
      out_sel_d   = grant;
      out_valid_d = 1'b1;
      // Move priority to the channel after the winner, so the winner
      // becomes the lowest priority on the next search.
      ptr_d       = (grant == SW'(N - 1)) ? '0 : grant + 1'b1;
    end else if (OUT_READY) begin
      // The held beat drains and nothing replaces it.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: Sequential state uses non-blocking assignments. Every register
      // then samples pre-edge values, whatever the process order.
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_SEL   = out_sel_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_reg
//
// Directed bench for mux_rr_reg with N=4, W=4. The stimulus pushes each hand-
// computed output beat {sel, data} into a queue. A monitor pops and compares on
// every output handshake. Combinational IN_READY and the hold/reset states are
// compared directly. Define MUX_RR_LOCK_EN to exercise the packet lock.
// -----------------------------------------------------------------------------
module tb_mux_rr_reg;

  localparam int N = 4;
  localparam int W = 4;

  logic           CLK;
  logic           RST;
  logic [N*W-1:0] IN_DATA;
  logic [N-1:0]   IN_VALID;
  logic [N-1:0]   IN_READY;
  logic [W-1:0]   OUT_DATA;
  logic [1:0]     OUT_SEL;
  logic           OUT_VALID;
  logic           OUT_READY;
`ifdef MUX_RR_LOCK_EN
  logic [N-1:0]   IN_LAST;
`endif

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];  // {sel, data}

  mux_rr_reg #(.N(N), .W(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_DATA  (IN_DATA),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .OUT_DATA (OUT_DATA),
    .OUT_SEL  (OUT_SEL),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY)
`ifdef MUX_RR_LOCK_EN
    ,
    .IN_LAST  (IN_LAST)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Check the expected IN_READY, queue the expected output beat, then let the
  // transfer happen at the next edge.
  task automatic beat(input logic [3:0] rdy, input logic [1:0] sel, input logic [3:0] dat);
    #1;
    check("in_ready", {28'd0, IN_READY}, {28'd0, rdy});
    exp_q.push_back({sel, dat});
    tick();
  endtask

  // Monitor: a beat leaves the DUT on every edge where OUT_VALID && OUT_READY
  // holds. Sampling on the falling edge avoids races with the rising edge.
  initial begin
    logic [5:0] exp;
    forever begin
      @(negedge CLK);
      if (!RST && OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got sel=%0d data=0x%0h with nothing queued at %0t",
                   OUT_SEL, OUT_DATA, $time);
        end else begin
          exp = exp_q.pop_front();
          check("out_beat", {26'd0, OUT_SEL, OUT_DATA}, {26'd0, exp});
        end
      end
    end
  end

  initial begin
    logic [3:0] oh;
    RST       = 1'b1;
    IN_VALID  = 4'b1111;
    IN_DATA   = 16'h8421;
    OUT_READY = 1'b1;
`ifdef MUX_RR_LOCK_EN
    IN_LAST   = 4'b0000;
`endif

    // Reset state: outputs cleared, and nothing is taken while RST is high.
    #2;
    check("rst_in_ready",  {28'd0, IN_READY}, 32'd0);
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_out_data",  {28'd0, OUT_DATA}, 32'd0);
    check("rst_out_sel",   {30'd0, OUT_SEL}, 32'd0);
    tick();
    tick();
    RST = 1'b0;

    // Single beat from ch0, one-cycle latency, then the register drains.
    IN_VALID = 4'b0001;
    beat(4'b0001, 2'd0, 4'h1);
    check("t1_out_valid", {31'd0, OUT_VALID}, 32'd1);
    IN_VALID = 4'b0000;
    tick();
    check("t1_drained", {31'd0, OUT_VALID}, 32'd0);

    // Reset pulse so the rotation starts again at ch0.
    RST = 1'b1;
    tick();
    RST = 1'b0;

    // All channels valid: the grant rotates 0,1,2,3,0,1,2,3 at one beat/cycle.
    IN_VALID = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      oh = 4'b0001 << (k % 4);
      beat(oh, 2'(k % 4), oh);
    end

    // Backpressure: the ch3 beat holds for three cycles while ch1/ch2 wait.
    OUT_READY = 1'b0;
    IN_VALID  = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_in_ready",  {28'd0, IN_READY}, 32'd0);
      check("hold_out_valid", {31'd0, OUT_VALID}, 32'd1);
      check("hold_out_sel",   {30'd0, OUT_SEL}, 32'd3);
      check("hold_out_data",  {28'd0, OUT_DATA}, 32'h8);
      tick();
    end
    OUT_READY = 1'b1;
    beat(4'b0010, 2'd1, 4'h2);   // PTR was 0 -> ch1
    beat(4'b0100, 2'd2, 4'h4);   // PTR 2 -> ch2

    // Wrap: PTR=3 with only ch0 and ch2 valid -> ch0, then ch2.
    IN_VALID = 4'b0101;
    IN_DATA  = 16'h8E21;
    beat(4'b0001, 2'd0, 4'h1);
    beat(4'b0100, 2'd2, 4'hE);

    // Reset mid-operation while a 4'b1011 beat is held.
    IN_VALID = 4'b0001;
    IN_DATA  = 16'h8E2B;
    beat(4'b0001, 2'd0, 4'hB);  // PTR becomes 1
    OUT_READY = 1'b0;
    IN_VALID  = 4'b0000;
    #1;
    check("pre_rst_valid", {31'd0, OUT_VALID}, 32'd1);
    check("pre_rst_data",  {28'd0, OUT_DATA}, 32'hB);
    RST      = 1'b1;
    IN_VALID = 4'b1111;
    #1;
    check("async_rst_valid",    {31'd0, OUT_VALID}, 32'd0);
    check("async_rst_data",     {28'd0, OUT_DATA}, 32'd0);
    check("async_rst_sel",      {30'd0, OUT_SEL}, 32'd0);
    check("async_rst_in_ready", {28'd0, IN_READY}, 32'd0);
    void'(exp_q.pop_back());    // the held beat is discarded by reset
    tick();
    RST = 1'b0;
    #1;
    check("restart_ch0", {28'd0, IN_READY}, 32'b0001);
    OUT_READY = 1'b1;
    beat(4'b0001, 2'd0, 4'hB);  // PTR becomes 1

`ifdef MUX_RR_LOCK_EN
    // Packet lock: ch1 sends 3 beats (last on the third) while ch0/ch2 stay valid.
    IN_VALID = 4'b0111;
    IN_LAST  = 4'b0000;
    beat(4'b0010, 2'd1, 4'h2);  // locks ch1
    beat(4'b0010, 2'd1, 4'h2);  // still locked, although PTR points at ch2
    IN_VALID = 4'b0101;          // ch1 idle: no other channel is served
    #1;
    check("lock_idle_in_ready", {28'd0, IN_READY}, 32'd0);
    tick();
    IN_VALID = 4'b0111;
    IN_LAST  = 4'b0010;
    beat(4'b0010, 2'd1, 4'h2);  // last beat, unlocks, PTR=2
    IN_LAST  = 4'b0000;
    beat(4'b0100, 2'd2, 4'hE);
`endif

    // Drain everything still queued, with a bounded wait.
    IN_VALID = 4'b0000;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    tick();
    check("final_out_valid", {31'd0, OUT_VALID}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised successor to the team's combinational 2:1 mux: N input channels of W bits, each with a valid/ready handshake.
- Round-robin arbitration selects one channel per cycle; the selected data is captured in a single output register.
- Feeds datapath stages that need fair sharing of one bus among several producers, with backpressure and a registered output.

Parameters:
- N, 4, number of input channels (N >= 2).
- W, 4, data width per channel in bits.
- SW, $clog2(N), width of the channel index (derived, not overridden).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_DATA  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- IN_VALID  input  N  channel i presents valid data.
- IN_READY  output  N  channel i's beat is taken this cycle.
- OUT_DATA  output  W  registered data of the granted beat.
- OUT_SEL  output  SW  index of the channel that produced OUT_DATA.
- OUT_VALID  output  1  OUT_DATA/OUT_SEL hold a beat.
- OUT_READY  input  1  downstream accepts the beat.
- IN_LAST  input  N  last beat of a packet on channel i; present only with MUX_RR_LOCK_EN.

Behaviour:
- Reset (async assert, sync release): OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, rotation pointer PTR=0. IN_READY is all-zero while RST=1.
- The output register can accept a beat when ACC = !OUT_VALID || OUT_READY.
- Grant: the first i with IN_VALID[i]=1, searching from PTR upward with wrap modulo N. No grant if IN_VALID is all zero.
- IN_READY[g] = ACC && grant valid, for the granted index g only. IN_READY is combinational from IN_VALID, PTR, OUT_VALID and OUT_READY. At most one IN_READY bit is high per cycle.
- On transfer (IN_VALID[g] && IN_READY[g]) at a clock edge:
  - OUT_DATA <= channel g data, OUT_SEL <= g, OUT_VALID <= 1.
  - PTR <= g+1, wrapping from N-1 to 0.
- If ACC and there is no grant: OUT_VALID <= 0 when OUT_READY=1, and PTR is unchanged.
- If OUT_VALID=1 and OUT_READY=0: OUT_DATA, OUT_SEL, OUT_VALID and PTR all hold, and no IN_READY is asserted.
- Latency is 1 cycle from input transfer to OUT_VALID. Sustained throughput is 1 beat/cycle when OUT_READY is held high.
- Fairness: with all channels continuously valid, grants follow PTR, PTR+1, ... with no channel starved. The worst-case wait is N-1 accepted beats.
- Simultaneous output drain and input accept in the same cycle: the new beat replaces the old one with no bubble.
- Reset mid-operation: a held beat is discarded, OUT_VALID drops immediately, and arbitration restarts at channel 0.
- Inputs are expected to hold data stable while valid and not ready. The block does not check this.

Optional Feature:
- Macro MUX_RR_LOCK_EN.
- Defined:
  - IN_LAST port exists.
  - Two-state lock FSM: UNLOCKED / LOCKED(ch).
  - UNLOCKED: arbitration as above. A transfer with IN_LAST[g]=0 moves to LOCKED(g).
  - LOCKED(ch): grant is forced to ch, and other channels get IN_READY=0 even if ch is idle.
  - A transfer from ch with IN_LAST[ch]=1 returns to UNLOCKED, with PTR <= ch+1.
  - Reset returns to UNLOCKED.
- Undefined: no IN_LAST port, no FSM, and arbitration happens on every beat.

Test Plan:
- Reset, then IN_VALID=0001, IN_DATA ch0=4'b0001, OUT_READY=1 -> IN_READY=0001. Next cycle OUT_DATA=0001, OUT_SEL=0, OUT_VALID=1.
- All four valid, ch0..ch3 data = 0001/0010/0100/1000, OUT_READY=1 for 8 cycles -> OUT_SEL sequence 0,1,2,3,0,1,2,3 and OUT_DATA tracks it, one beat/cycle.
- Beat held (OUT_VALID=1) with OUT_READY=0 for 3 cycles while ch1 and ch2 are valid -> OUT_DATA/OUT_SEL stable, IN_READY=0000. Raise OUT_READY -> the next beat comes from PTR order.
- PTR=3 after granting ch2, only ch0 and ch2 valid (ch2 data 4'b1110) -> grant ch0 first, then ch2 (wrap check).
- Assert RST while OUT_VALID=1 and OUT_DATA=4'b1011 -> OUT_VALID=0, OUT_DATA=0 and OUT_SEL=0 asynchronously. After release, the first grant comes from channel 0.
- MUX_RR_LOCK_EN: ch1 sends 3 beats with IN_LAST=0,0,1 while ch0 and ch2 are continuously valid -> OUT_SEL=1,1,1, then 2.
